// File: rtl/spi_lut_config_seq.sv
// Walks an external {address, data} LUT and ships each entry as one SPI write frame,
// optionally followed by a read-back frame whose data byte is compared against the LUT.
module spi_lut_config_seq #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 10,
  parameter int LUT_DEPTH = 5,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 4,
  parameter int VERIFY    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [IDX_W-1:0]         lut_index,
  input  logic [ADDR_W+DATA_W-1:0] lut_data,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [IDX_W-1:0]         err_index
);
  localparam int FRAME_W = ADDR_W + DATA_W;
  // LOAD always costs one cs_n-high cycle, so GAP itself is one shorter.
  localparam int GAP_CYC = (CS_GAP > 1) ? CS_GAP - 1 : 1;
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, CHECK, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [DATA_W-1:0]  rx_reg, rx_next;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               sclk_reg, sclk_next;
  logic               cs_n_reg, cs_n_next;
  logic               mosi_reg, mosi_next;
  logic               rd_phase_reg, rd_phase_next;
  logic               err_reg, err_next;
  logic [IDX_W-1:0]   err_index_reg, err_index_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      frame_reg     <= '0;
      data_reg      <= '0;
      rx_reg        <= '0;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      sclk_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
      rd_phase_reg  <= 1'b0;
      err_reg       <= 1'b0;
      err_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      frame_reg     <= frame_next;
      data_reg      <= data_next;
      rx_reg        <= rx_next;
      div_cnt_reg   <= div_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      sclk_reg      <= sclk_next;
      cs_n_reg      <= cs_n_next;
      mosi_reg      <= mosi_next;
      rd_phase_reg  <= rd_phase_next;
      err_reg       <= err_next;
      err_index_reg <= err_index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    frame_next     = frame_reg;
    data_next      = data_reg;
    rx_next        = rx_reg;
    div_cnt_next   = div_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    sclk_next      = sclk_reg;
    cs_n_next      = cs_n_reg;
    mosi_next      = mosi_reg;
    rd_phase_next  = rd_phase_reg;
    err_next       = err_reg;
    err_index_next = err_index_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = LOAD;
          index_next     = '0;
          rd_phase_next  = 1'b0;
          err_next       = 1'b0;
          err_index_next = '0;
        end
      end
      LOAD: begin
        if (index_reg == LAST_IDX || &lut_data) begin
          state_next = DONE;
        end else begin
          // The address MSB carries the R/W flag on the wire.
          frame_next   = {rd_phase_reg, lut_data[FRAME_W-2:0]};
          data_next    = lut_data[DATA_W-1:0];
          mosi_next    = rd_phase_reg;
          cs_n_next    = 1'b0;
          sclk_next    = 1'b0;
          div_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          sclk_next    = ~sclk_reg;
          if (!sclk_reg) begin
            rx_next = {rx_reg[DATA_W-2:0], miso};
          end else if (bit_cnt_reg == BIT_LAST) begin
            cs_n_next    = 1'b1;
            mosi_next    = 1'b0;
            gap_cnt_next = '0;
            state_next   = GAP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            frame_next   = {frame_reg[FRAME_W-2:0], 1'b0};
            mosi_next    = frame_reg[FRAME_W-2];
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (VERIFY == 0) begin
            index_next = index_reg + 1'b1;
            state_next = LOAD;
          end else if (!rd_phase_reg) begin
            rd_phase_next = 1'b1;
            state_next    = LOAD;
          end else begin
            state_next = CHECK;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      CHECK: begin
        if (rx_reg != data_reg) begin
          err_next       = 1'b1;
          err_index_next = index_reg;
          state_next     = DONE;
        end else begin
          index_next    = index_reg + 1'b1;
          rd_phase_next = 1'b0;
          state_next    = LOAD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign lut_index = index_reg;
  assign sclk      = sclk_reg;
  assign cs_n      = cs_n_reg;
  assign mosi      = mosi_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;
  assign err_index = err_index_reg;
endmodule

// File: tb/tb_spi_lut_config_seq.sv
// Scoreboard bench: one default-parameter sequencer and one read-back-verifying instance,
// each watched by an SPI slave model that captures frames, cs_n timing and drives miso.
module tb_spi_lut_config_seq;
  typedef struct {
    logic [23:0] frame;
    int          bits;
    int          low;
    logic        sclk_end;
  } frm_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic a_start = 1'b0, v_start = 1'b0;
  logic [9:0] a_idx, v_idx, a_err_index, v_err_index;
  logic [23:0] a_data, v_data;
  logic a_sclk, a_cs_n, a_mosi, a_busy, a_done, a_err;
  logic v_sclk, v_cs_n, v_mosi, v_busy, v_done, v_err;
  logic v_miso = 1'b0;

  logic [23:0] lut [0:7];
  logic [7:0]  mem [0:15];
  bit fault_mode = 1'b0;

  assign a_data = (a_idx < 10'd8) ? lut[a_idx[2:0]] : 24'hFFFFFF;
  assign v_data = (v_idx < 10'd8) ? lut[v_idx[2:0]] : 24'hFFFFFF;

  spi_lut_config_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .lut_index(a_idx), .lut_data(a_data),
    .sclk(a_sclk), .cs_n(a_cs_n), .mosi(a_mosi), .miso(1'b0),
    .busy(a_busy), .done(a_done), .err(a_err), .err_index(a_err_index)
  );

  spi_lut_config_seq #(.LUT_DEPTH(8), .VERIFY(1)) u_dut_v (
    .clk(clk), .rst_n(rst_n), .start(v_start), .lut_index(v_idx), .lut_data(v_data),
    .sclk(v_sclk), .cs_n(v_cs_n), .mosi(v_mosi), .miso(v_miso),
    .busy(v_busy), .done(v_done), .err(v_err), .err_index(v_err_index)
  );

  int checks_total = 0;
  int checks_passed = 0;

  frm_t a_got[$], v_got[$];
  int a_gap[$];
  logic [23:0] a_exp[$], v_exp[$];

  // Slave model for instance A: captures mosi on sclk rise, times cs_n low/high.
  initial begin
    logic a_prev_cs, a_prev_sclk;
    logic [23:0] a_sh;
    int a_bits, a_low, a_high;
    a_prev_cs = 1'b1; a_prev_sclk = 1'b0; a_sh = '0; a_bits = 0; a_low = 0; a_high = 0;
    forever begin
      @(negedge clk);
      if (!a_cs_n) begin
        if (a_prev_cs) begin
          a_gap.push_back(a_high);
          a_sh = '0; a_bits = 0; a_low = 0;
        end
        a_low++;
        if (a_sclk && !a_prev_sclk) begin
          a_sh = {a_sh[22:0], a_mosi};
          a_bits++;
        end
      end else begin
        if (!a_prev_cs) begin
          a_got.push_back('{frame: a_sh, bits: a_bits, low: a_low, sclk_end: a_sclk});
          a_high = 0;
        end
        a_high++;
      end
      a_prev_cs = a_cs_n;
      a_prev_sclk = a_sclk;
    end
  end

  // Slave model for instance V: stores written bytes, answers reads from that store.
  initial begin
    logic v_prev_cs, v_prev_sclk;
    logic [23:0] v_sh;
    logic [7:0] v_resp;
    logic [2:0] v_sel;
    int v_bits, v_low;
    v_prev_cs = 1'b1; v_prev_sclk = 1'b0; v_sh = '0; v_resp = '0; v_bits = 0; v_low = 0;
    forever begin
      @(negedge clk);
      if (!v_cs_n) begin
        if (v_prev_cs) begin
          v_sh = '0; v_bits = 0; v_low = 0;
        end
        v_low++;
        if (v_sclk && !v_prev_sclk) begin
          v_sh = {v_sh[22:0], v_mosi};
          v_bits++;
        end
        if (!v_sclk && v_prev_sclk && v_bits >= 16 && v_bits < 24) begin
          if (v_bits == 16)
            v_resp = (fault_mode && v_sh[14:0] == 15'd2) ? 8'h05 : mem[v_sh[3:0]];
          v_sel = 3'(23 - v_bits);
          v_miso = v_resp[v_sel];
        end
      end else begin
        if (!v_prev_cs) begin
          v_got.push_back('{frame: v_sh, bits: v_bits, low: v_low, sclk_end: v_sclk});
          if (!v_sh[23] && v_bits == 24) mem[v_sh[11:8]] = v_sh[7:0];
        end
        v_miso = 1'b0;
      end
      v_prev_cs = v_cs_n;
      v_prev_sclk = v_sclk;
    end
  end

  task automatic load_default_lut();
    lut[0] = 24'h000080; lut[1] = 24'h000100; lut[2] = 24'h000201;
    lut[3] = 24'h000304; lut[4] = 24'h000400;
    lut[5] = 24'hFFFFFF; lut[6] = 24'hFFFFFF; lut[7] = 24'hFFFFFF;
  endtask

  task automatic pulse_start(input bit use_v);
    @(negedge clk);
    if (use_v) v_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    v_start = 1'b0;
  endtask

  task automatic run_wait(input bit use_v, input int max_cyc, output int dones, output bit tmo);
    dones = 0;
    tmo = 1'b1;
    for (int c = 0; c < max_cyc && tmo; c++) begin
      @(negedge clk);
      if ((use_v ? v_done : a_done) === 1'b1) dones++;
      if (dones > 0 && (use_v ? v_busy : a_busy) === 1'b0) tmo = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      if ((use_v ? v_done : a_done) === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks_total++;
    if ({a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_err} !== 6'b100000)
      $display("FAIL reset_a_ctrl got=%b want=100000", {a_cs_n, a_sclk, a_mosi, a_busy, a_done, a_err});
    else checks_passed++;
    checks_total++;
    if (a_idx !== 10'd0 || a_err_index !== 10'd0)
      $display("FAIL reset_a_index got idx=%0d err_index=%0d want 0/0", a_idx, a_err_index);
    else checks_passed++;
    checks_total++;
    if ({v_cs_n, v_sclk, v_mosi, v_busy, v_done, v_err} !== 6'b100000 || v_idx !== 10'd0 || v_err_index !== 10'd0)
      $display("FAIL reset_v_state got=%b idx=%0d err_index=%0d want=100000 0 0",
               {v_cs_n, v_sclk, v_mosi, v_busy, v_done, v_err}, v_idx, v_err_index);
    else checks_passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks_total++;
    if (a_cs_n !== 1'b1 || a_busy !== 1'b0)
      $display("FAIL reset_release_idle got cs_n=%b busy=%b want 1/0", a_cs_n, a_busy);
    else checks_passed++;
    $display("test_reset done");
  endtask

  task automatic test_sequence();
    int dones; bit tmo; frm_t f; logic [23:0] e;
    load_default_lut();
    a_got.delete(); a_gap.delete(); a_exp.delete();
    for (int i = 0; i < 5; i++) a_exp.push_back({1'b0, lut[i][22:0]});
    pulse_start(1'b0);
    checks_total++;
    if (a_busy !== 1'b1 || a_cs_n !== 1'b1)
      $display("FAIL seq_load_cycle got busy=%b cs_n=%b want 1/1", a_busy, a_cs_n);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (a_cs_n !== 1'b0 || a_mosi !== 1'b0)
      $display("FAIL seq_shift_entry got cs_n=%b mosi=%b want 0/0", a_cs_n, a_mosi);
    else checks_passed++;
    run_wait(1'b0, 3000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1) $display("FAIL seq_done got timeout=%0d dones=%0d want 0/1", tmo, dones);
    else checks_passed++;
    checks_total++;
    if (a_idx !== 10'd5 || a_err !== 1'b0)
      $display("FAIL seq_end_state got idx=%0d err=%b want 5/0", a_idx, a_err);
    else checks_passed++;
    checks_total++;
    if (a_got.size() != 5) $display("FAIL seq_frame_count got=%0d want=5", a_got.size());
    else checks_passed++;
    while (a_got.size() > 0 && a_exp.size() > 0) begin
      f = a_got.pop_front(); e = a_exp.pop_front();
      checks_total++;
      if (f.frame !== e || f.bits != 24 || f.low != 96 || f.sclk_end !== 1'b0)
        $display("FAIL seq_frame got=%06h bits=%0d low=%0d sclk=%b want=%06h bits=24 low=96 sclk=0",
                 f.frame, f.bits, f.low, f.sclk_end, e);
      else checks_passed++;
      $display("seq frame %06h low=%0d", f.frame, f.low);
    end
    checks_total++;
    if (a_gap.size() != 5) $display("FAIL seq_gap_count got=%0d want=5", a_gap.size());
    else checks_passed++;
    for (int i = 1; i < a_gap.size(); i++) begin
      checks_total++;
      if (a_gap[i] != 4) $display("FAIL seq_gap got=%0d want=4", a_gap[i]);
      else checks_passed++;
    end
  endtask

  task automatic test_all_ones();
    int dones; bit tmo; frm_t f; logic [23:0] e;
    load_default_lut();
    lut[2] = 24'hFFFFFF;
    a_got.delete(); a_exp.delete();
    for (int i = 0; i < 2; i++) a_exp.push_back({1'b0, lut[i][22:0]});
    pulse_start(1'b0);
    run_wait(1'b0, 3000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1 || a_idx !== 10'd2)
      $display("FAIL ones_end got timeout=%0d dones=%0d idx=%0d want 0/1/2", tmo, dones, a_idx);
    else checks_passed++;
    checks_total++;
    if (a_got.size() != 2) $display("FAIL ones_frame_count got=%0d want=2", a_got.size());
    else checks_passed++;
    while (a_got.size() > 0 && a_exp.size() > 0) begin
      f = a_got.pop_front(); e = a_exp.pop_front();
      checks_total++;
      if (f.frame !== e || f.bits != 24) $display("FAIL ones_frame got=%06h want=%06h", f.frame, e);
      else checks_passed++;
      $display("ones frame %06h", f.frame);
    end
    load_default_lut();
  endtask

  task automatic test_back_to_back();
    int dones; bit tmo; frm_t f; logic [23:0] e;
    load_default_lut();
    a_got.delete(); a_exp.delete();
    for (int i = 0; i < 5; i++) a_exp.push_back({1'b0, lut[i][22:0]});
    pulse_start(1'b0);
    repeat (150) @(negedge clk);
    pulse_start(1'b0);
    run_wait(1'b0, 3000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1) $display("FAIL b2b_done got timeout=%0d dones=%0d want 0/1", tmo, dones);
    else checks_passed++;
    checks_total++;
    if (a_got.size() != 5) $display("FAIL b2b_frame_count got=%0d want=5", a_got.size());
    else checks_passed++;
    while (a_got.size() > 0 && a_exp.size() > 0) begin
      f = a_got.pop_front(); e = a_exp.pop_front();
      checks_total++;
      if (f.frame !== e) $display("FAIL b2b_frame got=%06h want=%06h", f.frame, e);
      else checks_passed++;
      $display("b2b frame %06h", f.frame);
    end
  endtask

  task automatic test_verify_echo();
    int dones; bit tmo; frm_t f; logic [23:0] e;
    load_default_lut();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    fault_mode = 1'b0;
    v_got.delete(); v_exp.delete();
    for (int i = 0; i < 5; i++) begin
      v_exp.push_back({1'b0, lut[i][22:0]});
      v_exp.push_back({1'b1, lut[i][22:0]});
    end
    pulse_start(1'b1);
    run_wait(1'b1, 5000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1 || v_err !== 1'b0 || v_idx !== 10'd5)
      $display("FAIL echo_end got timeout=%0d dones=%0d err=%b idx=%0d want 0/1/0/5", tmo, dones, v_err, v_idx);
    else checks_passed++;
    checks_total++;
    if (v_got.size() != 10) $display("FAIL echo_frame_count got=%0d want=10", v_got.size());
    else checks_passed++;
    while (v_got.size() > 0 && v_exp.size() > 0) begin
      f = v_got.pop_front(); e = v_exp.pop_front();
      checks_total++;
      if (f.frame !== e || f.bits != 24 || f.low != 96)
        $display("FAIL echo_frame got=%06h bits=%0d low=%0d want=%06h bits=24 low=96", f.frame, f.bits, f.low, e);
      else checks_passed++;
      $display("echo frame %06h", f.frame);
    end
  endtask

  task automatic test_verify_error();
    int dones; bit tmo; frm_t f; logic [23:0] e;
    load_default_lut();
    fault_mode = 1'b1;
    v_got.delete(); v_exp.delete();
    for (int i = 0; i < 3; i++) begin
      v_exp.push_back({1'b0, lut[i][22:0]});
      v_exp.push_back({1'b1, lut[i][22:0]});
    end
    pulse_start(1'b1);
    run_wait(1'b1, 5000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1) $display("FAIL verr_done got timeout=%0d dones=%0d want 0/1", tmo, dones);
    else checks_passed++;
    checks_total++;
    if (v_err !== 1'b1 || v_err_index !== 10'd2 || v_idx !== 10'd2)
      $display("FAIL verr_flag got err=%b err_index=%0d idx=%0d want 1/2/2", v_err, v_err_index, v_idx);
    else checks_passed++;
    checks_total++;
    if (v_got.size() != 6) $display("FAIL verr_frame_count got=%0d want=6", v_got.size());
    else checks_passed++;
    while (v_got.size() > 0 && v_exp.size() > 0) begin
      f = v_got.pop_front(); e = v_exp.pop_front();
      checks_total++;
      if (f.frame !== e) $display("FAIL verr_frame got=%06h want=%06h", f.frame, e);
      else checks_passed++;
      $display("verr frame %06h", f.frame);
    end
    fault_mode = 1'b0;
    pulse_start(1'b1);
    checks_total++;
    if (v_err !== 1'b0 || v_err_index !== 10'd0)
      $display("FAIL verr_clear got err=%b err_index=%0d want 0/0", v_err, v_err_index);
    else checks_passed++;
    run_wait(1'b1, 5000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1 || v_err !== 1'b0)
      $display("FAIL verr_rerun got timeout=%0d dones=%0d err=%b want 0/1/0", tmo, dones, v_err);
    else checks_passed++;
    v_got.delete();
  endtask

  task automatic test_reset_mid_frame();
    int dones, edges; bit tmo; logic ps; frm_t f; logic [23:0] e;
    load_default_lut();
    pulse_start(1'b0);
    edges = 0;
    ps = a_sclk;
    for (int c = 0; c < 500 && edges < 10; c++) begin
      @(negedge clk);
      if (a_sclk !== ps) edges++;
      ps = a_sclk;
    end
    checks_total++;
    if (edges != 10) $display("FAIL midrst_edges got=%0d want=10", edges);
    else checks_passed++;
    checks_total++;
    if (a_cs_n !== 1'b0) $display("FAIL midrst_in_frame got cs_n=%b want=0", a_cs_n);
    else checks_passed++;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (a_cs_n !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0 || a_idx !== 10'd0)
      $display("FAIL midrst_async got cs_n=%b sclk=%b busy=%b idx=%0d want 1/0/0/0", a_cs_n, a_sclk, a_busy, a_idx);
    else checks_passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    a_got.delete(); a_exp.delete();
    for (int i = 0; i < 5; i++) a_exp.push_back({1'b0, lut[i][22:0]});
    pulse_start(1'b0);
    run_wait(1'b0, 3000, dones, tmo);
    checks_total++;
    if (tmo || dones != 1) $display("FAIL midrst_rerun got timeout=%0d dones=%0d want 0/1", tmo, dones);
    else checks_passed++;
    checks_total++;
    if (a_got.size() != 5) $display("FAIL midrst_frame_count got=%0d want=5", a_got.size());
    else checks_passed++;
    while (a_got.size() > 0 && a_exp.size() > 0) begin
      f = a_got.pop_front(); e = a_exp.pop_front();
      checks_total++;
      if (f.frame !== e || f.low != 96) $display("FAIL midrst_frame got=%06h low=%0d want=%06h low=96", f.frame, f.low, e);
      else checks_passed++;
      $display("midrst frame %06h", f.frame);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_default_lut();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_sequence();
    test_all_ones();
    test_back_to_back();
    test_verify_echo();
    test_verify_error();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/spi_lut_config_seq.md
SPI_LUT_CONFIG_SEQ -- requirements
Module: spi_lut_config_seq

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, register-address field width.
REQ-002 SHALL provide parameter DATA_W, default 8, register-data field width; FRAME_W = ADDR_W+DATA_W.
REQ-003 SHALL provide parameter IDX_W, default 10, LUT index width.
REQ-004 SHALL provide parameter LUT_DEPTH, default 5, maximum entry count walked.
REQ-005 SHALL provide parameter CLK_DIV, default 2 (>=1), SCLK half-period in clk cycles.
REQ-006 SHALL provide parameter CS_GAP, default 4 (>=1), clk cycles cs_n held high between frames.
REQ-007 SHALL provide parameter VERIFY, default 0; 1 enables readback after each write.
REQ-008 clk  input  1  single system clock; all logic on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 start  input  1  one-cycle request to run the sequence.
REQ-011 lut_index  output  IDX_W  address to external combinational LUT.
REQ-012 lut_data  input  FRAME_W  {address, data} returned for lut_index, same cycle.
REQ-013 sclk, cs_n, mosi  output  1 each  SPI master lines.
REQ-014 miso  input  1  SPI readback data.
REQ-015 busy  output  1  high while the sequence runs.
REQ-016 done  output  1  one-cycle pulse at sequence end.
REQ-017 err  output  1  readback mismatch flag; err_index  output  IDX_W  failing entry.

Function
REQ-018 SHALL implement states IDLE, LOAD, SHIFT, GAP, CHECK, DONE.
REQ-019 IDLE: start=1 -> LOAD, lut_index=0, err cleared; start while busy SHALL be ignored.
REQ-020 LOAD: SHALL register lut_data; if lut_index==LUT_DEPTH or lut_data all-ones -> DONE, else -> SHIFT.
REQ-021 Frame SHALL be lut_data with its MSB replaced by R/W bit (0 write, 1 read), sent MSB first, FRAME_W bits.
REQ-022 SHIFT: cs_n=0 on SHIFT entry (2 clk after start sampled); mosi valid on entry, then changes CLK_DIV clk after each sclk rising edge (i.e. with sclk falling).
REQ-023 sclk SHALL idle low, toggle every CLK_DIV clk, give exactly FRAME_W rising edges, then return low before cs_n rises.
REQ-024 cs_n low time SHALL be exactly 2*CLK_DIV*FRAME_W clk cycles per frame.
REQ-025 miso SHALL be sampled on each sclk rising edge; last DATA_W samples form the readback byte.
REQ-026 GAP: cs_n=1 for CS_GAP cycles; then, VERIFY=0: lut_index+1 -> LOAD.
REQ-027 VERIFY=1: after a write frame, a read frame to the same address SHALL follow GAP; after its GAP -> CHECK.
REQ-028 CHECK: readback != data field -> err=1, err_index=lut_index, -> DONE; equal -> lut_index+1 -> LOAD.
REQ-029 DONE: done=1 for one cycle, busy=0 next cycle, -> IDLE; err/err_index SHALL hold until next start.
REQ-030 busy SHALL be 1 from the cycle after start is sampled through DONE inclusive.
REQ-031 lut_index SHALL stop at LUT_DEPTH, never wrap.
REQ-032 LUT_DEPTH=0 SHALL produce LOAD -> DONE with no cs_n activity.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, err=0, err_index=0, lut_index=0, all counters 0.
REQ-034 Reset mid-frame SHALL abort the frame with cs_n=1 at once; no resume after release; next start restarts at index 0.

Verification
REQ-035 Defaults, LUT {0000,80},{0001,00},{0002,01},{0003,04},{0004,00}, start -> five frames 0x000080,0x000100,0x000201,0x000304,0x000400; each cs_n low 96 clk; gaps 4 clk; one done pulse.
REQ-036 LUT_DEPTH=8, entry 2 = all-ones -> exactly two frames, then done; lut_index stops at 2.
REQ-037 VERIFY=1, miso model echoes written data -> frames alternate write/read (read frame 0x800080 for entry 0), err=0.
REQ-038 VERIFY=1, model returns 0x05 for address 0x0002 -> err=1, err_index=2, done pulses, no frame for entry 3.
REQ-039 rst_n low at 10th sclk edge of frame 1 -> cs_n=1, sclk=0 asynchronously; second start after release resends frame 0x000080 first.
REQ-040 start pulsed again while busy -> ignored; exactly five frames, one done.
